// File: rtl/csea_mp_seq.sv
// csea_mp_seq: multi-precision add/sub sequencer, one 16-bit limb per clock through a shared carry-select adder.
// Define CSEA_SEQ_SUB_EN to support A-B; without it Sub is ignored and every operation is A+B+Cin.

module csea16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] c;
    assign c[0] = cin;
    // Each 4-bit block precomputes both carry-in cases; the incoming carry only steers a mux.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] r0, r1;
        assign r0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign r1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;
        assign sum[4*g +: 4] = c[g] ? r1[3:0] : r0[3:0];
        assign c[g+1] = c[g] ? r1[4] : r0[4];
    end
    assign cout = c[4];
endmodule

module csea_mp_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic                Sub,
    input  logic                Cin,
    input  logic [16*WORDS-1:0] A,
    input  logic [16*WORDS-1:0] B,
    output logic                Busy,
    output logic                Done,
    output logic [16*WORDS-1:0] Sum,
    output logic                Cout,
    output logic                Ovf
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, next_state;
    logic [W-1:0]  a_q, b_q;
    logic          carry;
    logic [IW-1:0] idx;
    logic [W-1:0]  beff_in;
    logic          carry_in;
    logic [15:0]   a_limb, b_limb, limb_sum;
    logic          limb_cout;
    logic          accept, last;

`ifdef CSEA_SEQ_SUB_EN
    assign beff_in  = Sub ? ~B : B;
    assign carry_in = Sub | Cin;
`else
    logic sub_unused;
    assign sub_unused = Sub;
    assign beff_in    = B;
    assign carry_in   = Cin;
`endif

    assign accept = Start & (state != RUN);
    assign last   = idx == IW'(WORDS - 1);
    assign a_limb = a_q[16*idx +: 16];
    assign b_limb = b_q[16*idx +: 16];
    assign Busy   = state == RUN;
    assign Done   = state == DONE;

    csea16 u_add (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    always_comb begin
        next_state = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_q   <= A;
                b_q   <= beff_in;
                carry <= carry_in;
                idx   <= '0;
            end else if (state == RUN) begin
                Sum[16*idx +: 16] <= limb_sum;
                carry             <= limb_cout;
                idx               <= idx + IW'(1);
                if (last) begin
                    Cout <= limb_cout;
                    Ovf  <= (a_limb[15] == b_limb[15]) & (limb_sum[15] != a_limb[15]);
                end
            end
        end
    end
endmodule
